// File: rtl/acc_bank.sv
// acc_bank: partial-sum accumulator bank behind the systolic array.
// Entries are accumulated or overwritten from two write ports while idle, and
// drained in address order over a valid/ready stream. Each entry is cleared as
// its beat is accepted.
// Optional feature: define ACC_SATURATE_EN to make accumulation saturate at
// 2^PSUM_W-1 instead of wrapping modulo 2^PSUM_W.
module acc_bank #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int PSUM_W  = 45,
    parameter int CPSUM_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_wr_en,
    input  logic [ADDR_W-1:0] acc_wr_addr,
    input  logic              acc_first,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              cacc_wr_en,
    input  logic [ADDR_W-1:0] cacc_wr_addr,
    input  logic [CPSUM_W-1:0] cpsum_in,
    input  logic              rd_start,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PSUM_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              busy,
    output logic              wr_err
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t            state;
    logic [PSUM_W-1:0] mem [DEPTH];

    logic              idle;
    logic              acc_in_range;
    logic              cacc_in_range;
    logic              collide;
    logic              acc_do;
    logic              cacc_do;
    logic              err_next;
    logic              beat_done;
    logic [PSUM_W:0]   sum;
    logic [PSUM_W-1:0] acc_val;

    assign rd_data = mem[rd_addr];

    // Write-port arbitration: idle only, in-range only, compensation wins a collision.
    always_comb begin
        idle          = (state == IDLE);
        acc_in_range  = 32'(acc_wr_addr) < 32'(DEPTH);
        cacc_in_range = 32'(cacc_wr_addr) < 32'(DEPTH);
        collide       = acc_wr_en && cacc_wr_en && (acc_wr_addr == cacc_wr_addr);
        acc_do        = idle && acc_wr_en && acc_in_range && !collide;
        cacc_do       = idle && cacc_wr_en && cacc_in_range;
        err_next      = (acc_wr_en && !acc_do) || (cacc_wr_en && !cacc_do);
        beat_done     = (state == DRAIN) && rd_valid && rd_ready;
        sum           = {1'b0, mem[acc_wr_addr]} + {1'b0, psum_in};
`ifdef ACC_SATURATE_EN
        acc_val       = acc_first ? psum_in : (sum[PSUM_W] ? '1 : sum[PSUM_W-1:0]);
`else
        acc_val       = acc_first ? psum_in : sum[PSUM_W-1:0];
`endif
    end

    // Entry storage: accumulate/compensation writes while idle, clear-on-read while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (acc_do) begin
                mem[acc_wr_addr] <= acc_val;
            end
            if (cacc_do) begin
                mem[cacc_wr_addr] <= PSUM_W'(cpsum_in);
            end
            if (beat_done) begin
                mem[rd_addr] <= '0;
            end
        end
    end

    // Drain FSM with registered stream outputs and the write-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            wr_err <= err_next;
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        state    <= DRAIN;
                        rd_valid <= 1'b1;
                        busy     <= 1'b1;
                        rd_addr  <= '0;
                        rd_last  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (beat_done) begin
                        if (rd_last) begin
                            state    <= IDLE;
                            rd_valid <= 1'b0;
                            busy     <= 1'b0;
                            rd_addr  <= '0;
                            rd_last  <= 1'b0;
                        end else begin
                            rd_addr  <= rd_addr + ADDR_W'(1);
                            // rd_last is registered, so it is set one beat ahead.
                            rd_last  <= (rd_addr == ADDR_W'(DEPTH - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
